// File: rtl/fft_rescale_pkg.sv
// Shared definitions for the FFT output rescaler: saturation limits and
// frame-counter sizing.
package fft_rescale_pkg;

  // Number of bits needed to hold 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fft_rescale_if.sv
// Stream bus of the rescaler: truncated samples in, restored samples out.
interface fft_rescale_if #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4
);
  logic                      s_valid;
  logic                      s_ready;
  logic signed [IN_W-1:0]    s_data;
  logic        [SHIFT_W-1:0] s_shift;
  logic                      m_valid;
  logic                      m_ready;
  logic signed [OUT_W-1:0]   m_data;
  logic                      m_sat;
  logic                      m_last;

  // slave: the rescaler itself; master: whatever drives it and sinks results
  modport slave (
    input  s_valid, s_data, s_shift, m_ready,
    output s_ready, m_valid, m_data, m_sat, m_last
  );

  modport master (
    output s_valid, s_data, s_shift, m_ready,
    input  s_ready, m_valid, m_data, m_sat, m_last
  );
endinterface

// File: rtl/fft_rescale_sat.sv
// Combinational shift-left and saturate: widens the sample so no shift can
// overflow, then clamps into the signed OUT_W range.
module rescale_sat
  import fft_rescale_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic signed [IN_W-1:0]    data,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0]   result,
  output logic                      sat
);
  localparam int EXT_W = OUT_W + (1 << SHIFT_W);
  localparam logic signed [EXT_W-1:0] MAX_X = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MIN_X = EXT_W'(sat_min(OUT_W));
  localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(sat_min(OUT_W));

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] shifted;

  assign ext     = {{(EXT_W-IN_W){data[IN_W-1]}}, data};
  assign shifted = ext <<< shift;

  always_comb begin
    result = shifted[OUT_W-1:0];
    sat    = 1'b0;
    if (shifted > MAX_X) begin
      result = MAX_O;
      sat    = 1'b1;
    end else if (shifted < MIN_X) begin
      result = MIN_O;
      sat    = 1'b1;
    end
  end
endmodule

// File: rtl/fft_rescale.sv
// Two-stage rescaler restoring block-floating-point FFT output: stage 1 holds
// sample/exponent/last, stage 2 holds the shifted and saturated result.
module fft_rescale
  import fft_rescale_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int SHIFT_W   = 4,
  parameter int FRAME_LEN = 64
) (
  input logic         clk,
  input logic         rst_n,
  fft_rescale_if.slave bus
);
  localparam int CNT_W = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic                      v1_reg;
  logic signed [IN_W-1:0]    d1_reg;
  logic        [SHIFT_W-1:0] sh1_reg;
  logic                      last1_reg;
  logic        [SHIFT_W-1:0] exp_reg;
  logic        [CNT_W-1:0]   cnt_reg;
  logic                      m_valid_reg;
  logic signed [OUT_W-1:0]   m_data_reg;
  logic                      m_sat_reg;
  logic                      m_last_reg;

  logic                      advance;
  logic        [SHIFT_W-1:0] shift_sel;
  logic        [CNT_W-1:0]   cnt_next;
  logic signed [OUT_W-1:0]   sat_data;
  logic                      sat_flag;

  // The first sample of a frame uses the exponent presented alongside it.
  always_comb begin
    advance   = !m_valid_reg || bus.m_ready;
    shift_sel = (cnt_reg == '0) ? bus.s_shift : exp_reg;
    cnt_next  = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + CNT_W'(1);
  end

  rescale_sat #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_sat (
    .data   (d1_reg),
    .shift  (sh1_reg),
    .result (sat_data),
    .sat    (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg      <= 1'b0;
      d1_reg      <= '0;
      sh1_reg     <= '0;
      last1_reg   <= 1'b0;
      exp_reg     <= '0;
      cnt_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_sat_reg   <= 1'b0;
      m_last_reg  <= 1'b0;
    end else if (advance) begin
      v1_reg <= bus.s_valid;
      if (bus.s_valid) begin
        d1_reg    <= bus.s_data;
        sh1_reg   <= shift_sel;
        last1_reg <= (cnt_reg == LAST_CNT);
        cnt_reg   <= cnt_next;
        if (cnt_reg == '0) begin
          exp_reg <= bus.s_shift;
        end
      end
      m_valid_reg <= v1_reg;
      // Bubbles leave m_data untouched so a stale value never changes under a hold.
      if (v1_reg) begin
        m_data_reg <= sat_data;
        m_sat_reg  <= sat_flag;
        m_last_reg <= last1_reg;
      end else begin
        m_sat_reg  <= 1'b0;
        m_last_reg <= 1'b0;
      end
    end
  end

  assign bus.s_ready = advance;
  assign bus.m_valid = m_valid_reg;
  assign bus.m_data  = m_data_reg;
  assign bus.m_sat   = m_sat_reg;
  assign bus.m_last  = m_last_reg;
endmodule

// File: tb/tb_fft_rescale.sv
// Directed bench for fft_rescale with IN_W=8, OUT_W=16, SHIFT_W=4, FRAME_LEN=4.
module tb_fft_rescale;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_rescale_if #(.IN_W(8), .OUT_W(16), .SHIFT_W(4)) bus ();

  fft_rescale #(
    .IN_W      (8),
    .OUT_W     (16),
    .SHIFT_W   (4),
    .FRAME_LEN (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [17:0] out_q[$];
  logic [7:0]  vec_data[16];
  logic [3:0]  vec_shift[16];
  logic [15:0] exp_data[16];
  logic        exp_last[16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are captured mid-cycle, one line per completed output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      out_q.push_back({bus.m_last, bus.m_sat, $unsigned(bus.m_data)});
      $display("[TB] out data=0x%04h sat=%0b last=%0b", $unsigned(bus.m_data), bus.m_sat, bus.m_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    step();
    rst_n = 1'b1;
    out_q.delete();
  endtask

  task automatic single(input string tag, input logic [7:0] d, input logic [3:0] sh,
                        input logic [15:0] exp_d, input logic exp_s);
    do_reset();
    bus.s_data  = d;
    bus.s_shift = sh;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    check_val({tag, "_lat1_valid"}, 32'(bus.m_valid), 32'd0);
    step();
    check_val({tag, "_lat2_valid"}, 32'(bus.m_valid), 32'd1);
    check_val({tag, "_data"}, 32'($unsigned(bus.m_data)), 32'(exp_d));
    check_val({tag, "_sat"}, 32'(bus.m_sat), 32'(exp_s));
  endtask

  task automatic run_stream(input int n, input int stall_at, input int stall_len);
    int i;
    int cyc;
    logic [15:0] held;
    bit acc;
    i = 0;
    cyc = 0;
    held = '0;
    while (i < n && cyc < 200) begin
      bus.s_valid = 1'b1;
      bus.s_data  = vec_data[i];
      bus.s_shift = vec_shift[i];
      bus.m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (!bus.m_ready) begin
        check_val("stall_s_ready", 32'(bus.s_ready), 32'd0);
        if (cyc == stall_at) held = $unsigned(bus.m_data);
        else check_val("stall_hold", 32'($unsigned(bus.m_data)), 32'(held));
      end
      acc = bus.s_valid && bus.s_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    if (i < n) check_val("stream_timeout", 32'(i), 32'(n));
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic check_out(input string tag, input int n);
    check_val({tag, "_count"}, 32'(out_q.size()), 32'(n));
    for (int k = 0; k < n && k < out_q.size(); k++) begin
      check_val($sformatf("%s_data%0d", tag, k), 32'(out_q[k][15:0]), 32'(exp_data[k]));
      check_val($sformatf("%s_last%0d", tag, k), 32'(out_q[k][17]), 32'(exp_last[k]));
      check_val($sformatf("%s_sat%0d", tag, k), 32'(out_q[k][16]), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with input offered that must not be taken.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h7F;
    bus.s_shift = 4'd3;
    bus.m_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_val("rst_m_data", 32'($unsigned(bus.m_data)), 32'd0);
    check_val("rst_m_sat", 32'(bus.m_sat), 32'd0);
    check_val("rst_m_last", 32'(bus.m_last), 32'd0);
    check_val("rst_s_ready", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    check_val("rst_no_accept", 32'(bus.m_valid), 32'd0);

    // Single-sample shift and saturation corners.
    single("basic_40_s3", 8'h40, 4'd3, 16'h0200, 1'b0);
    single("pos_sat_7f_s9", 8'h7F, 4'd9, 16'h7FFF, 1'b1);
    single("neg_edge_80_s8", 8'h80, 4'd8, 16'h8000, 1'b0);
    single("neg_sat_80_s9", 8'h80, 4'd9, 16'h8000, 1'b1);
    single("minus1_s0", 8'hFF, 4'd0, 16'hFFFF, 1'b0);
    single("zero_s15", 8'h00, 4'd15, 16'h0000, 1'b0);

    // Exponent latched only at frame start; next frame picks up 5.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      vec_data[k]  = 8'h01;
      vec_shift[k] = (k == 0) ? 4'd2 : 4'd5;
      exp_data[k]  = (k < 4) ? 16'h0004 : 16'h0020;
      exp_last[k]  = (k == 3 || k == 7);
    end
    run_stream(8, -1, 0);
    check_out("frame", 8);

    // Backpressure: three cycles of m_ready low mid-stream.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      vec_data[k]  = 8'(k + 1);
      vec_shift[k] = 4'd1;
      exp_data[k]  = 16'(2 * (k + 1));
      exp_last[k]  = (k == 3);
    end
    run_stream(6, 3, 3);
    check_out("stall", 6);

    // Reset after two samples of a frame, then a fresh full frame.
    do_reset();
    bus.m_ready = 1'b1;
    bus.s_data  = 8'h01;
    bus.s_shift = 4'd1;
    bus.s_valid = 1'b1;
    step();
    step();
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    out_q.delete();
    for (int k = 0; k < 4; k++) begin
      vec_data[k]  = 8'(k + 1);
      vec_shift[k] = 4'd3;
      exp_data[k]  = 16'(8 * (k + 1));
      exp_last[k]  = (k == 3);
    end
    run_stream(4, -1, 0);
    check_out("midrst", 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
